// File: rtl/paro_rampa_parcial.sv
// Soft-stop controller: walks a motor down 100% -> 50% -> 30% -> off,
// holding each level for a profile-dependent number of slow ticks.
// A built-in prescaler derives the slow tick from the chip clock.
module paro_rampa_parcial #(
  parameter int TICK_DIV   = 10000000,
  parameter int DWELL_FAST = 2,
  parameter int DWELL_NORM = 4,
  parameter int DWELL_SLOW = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stop,
  input  logic       estop,
  input  logic       rapido,
  input  logic       lento,
  input  logic [2:0] lvl_in,
  output logic       out_30,
  output logic       out_50,
  output logic       out_100,
  output logic       busy,
  output logic       done
);

  localparam int MAX_FN    = (DWELL_FAST > DWELL_NORM) ? DWELL_FAST : DWELL_NORM;
  localparam int MAX_DWELL = (MAX_FN > DWELL_SLOW) ? MAX_FN : DWELL_SLOW;
  localparam int DW        = $clog2(MAX_DWELL + 1);
  localparam int TW        = $clog2(TICK_DIV);

  typedef enum logic [2:0] {IDLE, S100, S50, S30, DONE} state_t;

  state_t          state, next_state;
  logic [TW-1:0]   tick_cnt;
  logic [DW-1:0]   dwell_cnt;
  logic [DW-1:0]   dwell;
  logic [DW-1:0]   dwell_sel;
  logic            accept;
  logic            active;
  logic            tick;
  logic            expire;

  assign accept = (state == IDLE) && stop && !estop;
  assign active = (state == S100) || (state == S50) || (state == S30);
  assign tick   = active && (tick_cnt == TW'(TICK_DIV - 1));
  assign expire = tick && (dwell_cnt == dwell - DW'(1));

  // Profile decode: exactly one of rapido/lento picks fast/slow, anything else is normal
  always_comb begin
    dwell_sel = DW'(DWELL_NORM);
    if (rapido && !lento) begin
      dwell_sel = DW'(DWELL_FAST);
    end else if (lento && !rapido) begin
      dwell_sel = DW'(DWELL_SLOW);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; estop outranks both stop and a simultaneous dwell expiry
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (lvl_in[2]) begin
            next_state = S100;
          end else if (lvl_in[1]) begin
            next_state = S50;
          end else if (lvl_in[0]) begin
            next_state = S30;
          end else begin
            next_state = DONE;
          end
        end
      end
      S100: begin
        if (estop) begin
          next_state = DONE;
        end else if (expire) begin
          next_state = S50;
        end
      end
      S50: begin
        if (estop) begin
          next_state = DONE;
        end else if (expire) begin
          next_state = S30;
        end
      end
      S30: begin
        if (estop || expire) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Prescaler and dwell counters run only in the level states; profile latched on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      dwell_cnt <= '0;
      dwell     <= DW'(DWELL_NORM);
    end else if (!active) begin
      tick_cnt  <= '0;
      dwell_cnt <= '0;
      if (accept) begin
        dwell <= dwell_sel;
      end
    end else if (tick) begin
      tick_cnt <= '0;
      if (expire) begin
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_100 <= 1'b0;
      out_50  <= 1'b0;
      out_30  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      out_100 <= (next_state == S100);
      out_50  <= (next_state == S50);
      out_30  <= (next_state == S30);
      busy    <= (next_state == S100) || (next_state == S50) || (next_state == S30);
      done    <= (next_state == DONE);
    end
  end

endmodule
